// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared FP32 constants and the sign-guarded maximum used by the 2x2 pooling stage.
// Inputs are ReLU outputs, so the max reduces to an unsigned compare of bit patterns.
package maxpool_2x2_stream_pkg;

   localparam int          FP_WIDTH = 32;
   localparam int          SIGN_BIT = 31;
   localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

   // Negative patterns (including -0) collapse to +0 so they never win a compare.
   function automatic logic [FP_WIDTH-1:0] fp_sanitize(input logic [FP_WIDTH-1:0] a);
      return a[SIGN_BIT] ? FP_ZERO : a;
   endfunction

   // Operand a is the earlier pixel; it is kept on ties.
   function automatic logic [FP_WIDTH-1:0] fp_sanitize_max(input logic [FP_WIDTH-1:0] a,
                                                           input logic [FP_WIDTH-1:0] b);
      logic [FP_WIDTH-1:0] sa;
      logic [FP_WIDTH-1:0] sb;
      sa = fp_sanitize(a);
      sb = fp_sanitize(b);
      return (sb > sa) ? sb : sa;
   endfunction

endpackage

// File: rtl/maxpool_2x2_stream_pool_line_buffer.sv
// Half-width row store holding the horizontal maxima of each even row.
// Synchronous write, combinational read, no reset: every entry is written before it is read.
module pool_line_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 112,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pool: even rows fill a half-width line buffer with pair maxima,
// odd rows combine their pair maxima with the buffered value and emit one pooled pixel per pair.
module maxpool_2x2_stream
   import maxpool_2x2_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 224,
   parameter int IMG_HEIGHT = 224
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  valid_out,
   output logic                  frame_done
);

   localparam int HALF_W = IMG_WIDTH / 2;
   localparam int CW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [DATA_WIDTH-1:0] h_reg;

   logic [CW-1:0]         col_half;
   logic [AW-1:0]         buf_addr;
   logic                  buf_we;
   logic [DATA_WIDTH-1:0] buf_rd;
   logic [DATA_WIDTH-1:0] hmax;
   logic [DATA_WIDTH-1:0] pooled;
   logic                  col_last;
   logic                  row_last;

   assign col_half = col >> 1;
   assign buf_addr = col_half[AW-1:0];
   assign col_last = (col == CW'(IMG_WIDTH - 1));
   assign row_last = (row == RW'(IMG_HEIGHT - 1));

   assign hmax   = fp_sanitize_max(h_reg, i_data);
   assign pooled = fp_sanitize_max(buf_rd, hmax);
   assign buf_we = valid_in && col[0] && !row[0];

   pool_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (HALF_W),
      .AW         (AW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (buf_we),
      .addr  (buf_addr),
      .wdata (hmax),
      .rdata (buf_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col        <= '0;
         row        <= '0;
         h_reg      <= '0;
         o_data     <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            if (!col[0]) begin
               h_reg <= fp_sanitize(i_data);
            end else if (row[0]) begin
               o_data     <= pooled;
               valid_out  <= 1'b1;
               frame_done <= row_last && col_last;
            end

            // Raster-order position; the next frame follows without an idle beat.
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule
